// File: rtl/tmr0_wdt_prescaler.sv
// Timer-0 clock-source selection, shared TMR0/WDT prescaler and watchdog timer.
// Define TMR0_WDT_EN to build the watchdog base counter and the WDT side of the prescaler.
module tmr0_wdt_prescaler #(
  parameter int WDT_BASE_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       option_wr,
  input  logic [5:0] option_in,
  input  logic       tmr0_wr,
  input  logic       clrwdt,
  input  logic       sleep,
  input  logic       t0cki,
  output logic       tmr0_inc,
  output logic       wdtmr,
  output logic [5:0] option_q
);

  logic       t0cs;
  logic       t0se;
  logic       psa;
  logic [2:0] ps;
  assign {t0cs, t0se, psa, ps} = option_q;

  logic       s1, s2, s3;
  logic       pin_edge;
  logic       src;
  logic [7:0] cnt, cnt_d;
  logic [7:0] m_t;
  logic       tmr0_inc_d;
  logic       wdtmr_d;

  // Edge polarity and source use the OPTION value in force this cycle, so an
  // OPTION write only changes counting from the following cycle.
  assign pin_edge = t0se ? (~s2 & s3) : (s2 & ~s3);
  assign src      = t0cs ? pin_edge : 1'b1;

  // TMR0 terminal mask (2<<PS)-1 : 1:2 .. 1:256.
  assign m_t = 8'hFF >> (3'd7 - ps);

`ifdef TMR0_WDT_EN
  logic                  wdt_clr;
  logic                  wtick;
  logic [WDT_BASE_W-1:0] base;
  logic [7:0]            m_w;

  assign wdt_clr = clrwdt | sleep;
  // A base overflow coinciding with CLRWDT/SLEEP never becomes a tick.
  assign wtick   = (&base) & ~wdt_clr;
  // WDT terminal mask (1<<PS)-1 : 1:1 .. 1:128.
  assign m_w     = 8'h7F >> (3'd7 - ps);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      base <= '0;
    end else if (wdt_clr) begin
      base <= '0;
    end else begin
      base <= base + 1'b1;
    end
  end
`else
  logic unused_wdt_inputs;
  assign unused_wdt_inputs = ^{clrwdt, sleep};
  localparam int unused_base_w = WDT_BASE_W;
`endif

  // NOTE: every variable assigned here gets a default first, so no path
  // through the block leaves a value held and no latch is inferred.
  always_comb begin
    cnt_d      = cnt;
    tmr0_inc_d = 1'b0;
    wdtmr_d    = 1'b0;

    if (!psa) begin
      // Prescaler owned by TMR0.
      if (src) begin
        if ((cnt & m_t) == m_t) begin
          tmr0_inc_d = 1'b1;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt + 8'd1;
        end
      end
      if (tmr0_wr) begin
        tmr0_inc_d = 1'b0;
        cnt_d      = '0;
      end
    end else begin
      tmr0_inc_d = src;
    end

`ifdef TMR0_WDT_EN
    if (psa) begin
      // Prescaler owned by the watchdog.
      if (wtick) begin
        if ((cnt & m_w) == m_w) begin
          wdtmr_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 8'd1;
        end
      end
      if (wdt_clr) begin
        cnt_d = '0;
      end
    end else begin
      wdtmr_d = wtick;
    end
`endif

    if (option_wr) begin
      cnt_d = '0;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values; the reset branch sits inside the clocked block, making it
  // synchronous.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      s3       <= 1'b0;
      option_q <= 6'h3F;
      cnt      <= '0;
      tmr0_inc <= 1'b0;
      wdtmr    <= 1'b0;
    end else begin
      s1       <= t0cki;
      s2       <= s1;
      s3       <= s2;
      cnt      <= cnt_d;
      tmr0_inc <= tmr0_inc_d;
      wdtmr    <= wdtmr_d;
      if (option_wr) begin
        option_q <= option_in;
      end
    end
  end

endmodule

// File: tb/tb_tmr0_wdt_prescaler.sv
// Self-checking bench for tmr0_wdt_prescaler: directed test-plan steps plus a randomized
// phase, all compared against a ratio/counter model built from the behavioural rules.
module tb_tmr0_wdt_prescaler;

  localparam int W           = 4;
  localparam int BASE_PERIOD = 1 << W;
`ifdef TMR0_WDT_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic       option_wr = 1'b0;
  logic [5:0] option_in = '0;
  logic       tmr0_wr   = 1'b0;
  logic       clrwdt    = 1'b0;
  logic       sleep     = 1'b0;
  logic       t0cki     = 1'b0;
  logic       tmr0_inc;
  logic       wdtmr;
  logic [5:0] option_q;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  tmr0_wdt_prescaler #(.WDT_BASE_W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .option_wr (option_wr),
    .option_in (option_in),
    .tmr0_wr   (tmr0_wr),
    .clrwdt    (clrwdt),
    .sleep     (sleep),
    .t0cki     (t0cki),
    .tmr0_inc  (tmr0_inc),
    .wdtmr     (wdtmr),
    .option_q  (option_q)
  );

  always #5 clk = ~clk;

  // Reference model: OPTION value, prescaler event count, base cycle count and
  // the pin samples taken at past edges (index 0 = most recent).
  logic [5:0] m_opt;
  int         m_pre;
  int         m_base;
  bit         pin_hist[$];
  logic       e_inc;
  logic       e_wdt;

  task automatic model_reset();
    m_opt    = 6'h3F;
    m_pre    = 0;
    m_base   = 0;
    pin_hist = '{1'b0, 1'b0, 1'b0};
    e_inc    = 1'b0;
    e_wdt    = 1'b0;
  endtask

  task automatic model_step();
    bit t0cs, t0se, psa, src, wclr, wtick;
    int ps, ratio;
    if (!rst_n) begin
      model_reset();
      return;
    end
    t0cs = m_opt[5];
    t0se = m_opt[4];
    psa  = m_opt[3];
    ps   = int'(m_opt[2:0]);
    // Synchronised pin seen by the edge detector is the sample from two edges ago.
    if (!t0cs)     src = 1'b1;
    else if (t0se) src = !pin_hist[1] && pin_hist[2];
    else           src = pin_hist[1] && !pin_hist[2];
    wclr  = EN && (clrwdt || sleep);
    wtick = EN && (m_base == BASE_PERIOD - 1) && !wclr;
    e_inc = 1'b0;
    e_wdt = 1'b0;
    if (!psa) begin
      ratio = 2 << ps;
      if (src) begin
        if (m_pre == ratio - 1) begin e_inc = 1'b1; m_pre = 0; end
        else m_pre++;
      end
      if (tmr0_wr) begin e_inc = 1'b0; m_pre = 0; end
      e_wdt = wtick;
    end else begin
      e_inc = src;
      if (wtick) begin
        ratio = 1 << ps;
        if (m_pre == ratio - 1) begin e_wdt = 1'b1; m_pre = 0; end
        else m_pre++;
      end
      if (wclr) m_pre = 0;
    end
    if (EN) m_base = wclr ? 0 : (m_base + 1) % BASE_PERIOD;
    if (option_wr) begin m_pre = 0; m_opt = option_in; end
    pin_hist.push_front(t0cki);
    void'(pin_hist.pop_back());
  endtask

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic check_int(input string tag, input int got, input int exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge,
  // then the one-cycle strobes drop.
  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("tmr0_inc", 8'(tmr0_inc), 8'(e_inc));
    check("wdtmr", 8'(wdtmr), 8'(e_wdt));
    check("option_q", {2'b00, option_q}, {2'b00, m_opt});
    cyc++;
    option_wr = 1'b0;
    tmr0_wr   = 1'b0;
    clrwdt    = 1'b0;
    sleep     = 1'b0;
  endtask

  task automatic write_option(input logic [5:0] v);
    option_in = v;
    option_wr = 1'b1;
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int first, n_inc, n_wdt, hold;
    model_reset();

    // Reset and idle with reset OPTION (T0CKI source, PSA=1, WDT 1:128).
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    first = -1; n_inc = 0; n_wdt = 0;
    for (int k = 1; k <= 2100; k++) begin
      step();
      if (tmr0_inc) n_inc++;
      if (wdtmr) begin n_wdt++; if (first < 0) first = k; end
    end
    check_int("idle_tmr0_inc_count", n_inc, 0);
    check_int("idle_wdtmr_count", n_wdt, EN ? 1 : 0);
    check_int("idle_wdtmr_first", first, EN ? BASE_PERIOD * 128 : -1);

    // Internal source, TMR0 1:8, then a TMR0 write mid-period.
    write_option(6'b000_010);
    first = -1; n_inc = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (tmr0_inc) begin n_inc++; if (first < 0) first = k; end
    end
    check_int("div8_first", first, 8);
    check_int("div8_count", n_inc, 5);
    repeat (3) step();
    tmr0_wr = 1'b1;
    step();
    first = -1;
    for (int j = 1; j <= 20; j++) begin
      step();
      if (tmr0_inc && first < 0) first = j;
    end
    check_int("div8_after_tmr0_wr", first, 8);

    // T0CKI rising edges 1:1, pin toggled every 4 cycles.
    t0cki = 1'b0;
    write_option(6'b101_000);
    first = -1; n_inc = 0;
    for (int i = 0; i < 46; i++) begin
      if (i < 40 && i % 4 == 0) t0cki = ~t0cki;
      step();
      if (tmr0_inc) begin n_inc++; if (first < 0) first = i; end
    end
    check_int("rise_first_latency", first, 2);
    check_int("rise_count", n_inc, 5);

    // Same with falling-edge select.
    write_option(6'b111_000);
    first = -1; n_inc = 0;
    for (int i = 0; i < 46; i++) begin
      if (i < 40 && i % 4 == 0) t0cki = ~t0cki;
      step();
      if (tmr0_inc) begin n_inc++; if (first < 0) first = i; end
    end
    check_int("fall_first_latency", first, 6);
    check_int("fall_count", n_inc, 5);

    // Internal source, PSA=1 (TMR0 every cycle), WDT 1:1.
    write_option(6'b001_000);
    clrwdt = 1'b1;
    step();
    first = -1; n_inc = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (tmr0_inc) n_inc++;
      if (wdtmr && first < 0) first = k;
    end
    check_int("wdt_1to1_first", first, EN ? BASE_PERIOD : -1);
    check_int("psa1_internal_every_cycle", n_inc, 40);
    clrwdt = 1'b1;
    step();
    first = -1;
    for (int k = 1; k <= 40; k++) begin
      if (k == 15) clrwdt = 1'b1;
      step();
      if (wdtmr && first < 0) first = k;
    end
    check_int("wdt_clr_at_15_first", first, EN ? 15 + BASE_PERIOD : -1);

    // WDT 1:2: a CLRWDT colliding with a base overflow also empties the prescaler.
    write_option(6'b001_001);
    clrwdt = 1'b1;
    step();
    first = -1;
    for (int k = 1; k <= 80; k++) begin
      if (k == 2 * BASE_PERIOD) clrwdt = 1'b1;
      step();
      if (wdtmr && first < 0) first = k;
    end
    check_int("wdt_collision_first", first, EN ? 4 * BASE_PERIOD : -1);

    // Randomized traffic against the model.
    hold = 0;
    for (int k = 0; k < 3000; k++) begin
      rst_n = ($urandom_range(0, 499) != 0);
      if ($urandom_range(0, 39) == 0) begin
        option_wr = 1'b1;
        option_in = 6'($urandom);
      end
      tmr0_wr = ($urandom_range(0, 24) == 0);
      clrwdt  = ($urandom_range(0, 59) == 0);
      sleep   = ($urandom_range(0, 89) == 0);
      if (hold >= 2 && $urandom_range(0, 2) == 0) begin
        t0cki = ~t0cki;
        hold  = 0;
      end
      hold++;
      step();
    end
    rst_n = 1'b1;
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
